letc_core_csr_agent: RTL
========================

# letc_core_csr_agent

Pipeline-side initiator for the LETC Core explicit CSR software interface. Accepts one decoded Zicsr instruction at a time (CSRRW/CSRRS/CSRRC, register or immediate operand). It issues the read/legality probe to the CSR file and computes the read-modify-write value. It commits the write one cycle later and returns the old CSR value, or an illegal flag, to the pipeline over a valid/ready response channel. Sits between decode and writeback, driving the CSR file's explicit read port and explicit write port.

## Interface
- No parameters; widths fixed by `riscv_pkg`: `word_t` = 32 bits, `csr_idx_t` = 12 bits.
- `clk` in 1: core clock.
- `rst` in 1: asynchronous reset, active-high.
- `req_valid` in 1: decoded CSR instruction present.
- `req_ready` out 1: agent accepts the request this cycle.
- `req_op` in 2: 2'b01 RW, 2'b10 RS, 2'b11 RC, 2'b00 reserved.
- `req_idx` in 12: target CSR index.
- `req_operand` in 32: rs1 value or zero-extended uimm.
- `req_rd_zero` in 1: rd is x0.
- `req_src_zero` in 1: rs1 is x0 / uimm is 0.
- `flush` in 1: kill any uncommitted or unreturned operation.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: pipeline consumes the response.
- `rsp_rdata` out 32: old CSR value.
- `rsp_illegal` out 1: access illegal; raise an illegal-instruction trap.
- `csr_explicit_ren` out 1: read strobe to the CSR file.
- `csr_explicit_idx` out 12: read/check index.
- `csr_explicit_rdata` in 32: same-cycle read data.
- `csr_explicit_wcheck` out 1: request a write-legality check.
- `csr_explicit_illegal` in 1: same-cycle legality result.
- `csr_explicit_wen` out 1: write strobe.
- `csr_explicit_widx` out 12: write index.
- `csr_explicit_wdata` out 32: write data.

## Operation
- Accept = `req_valid & req_ready`. All read-side outputs are combinational and gated by accept; they are 0 otherwise.
- On accept:
  - `ren` = !(op==RW & rd_zero).
  - `wcheck` = (op==RW) | !src_zero.
  - `idx` = `req_idx`.
- Effective old value `old`:
  - `csr_explicit_rdata` when `ren`=1, otherwise 0.
  - Subject to bypass (see Configuration).
- Illegal = `csr_explicit_illegal` | (op==2'b00).
- New value:
  - RW: `operand`.
  - RS: `old | operand`.
  - RC: `old & ~operand`.
- Registered on accept:
  - `widx`, `wdata`.
  - `wpend` = wcheck & !illegal.
  - `rsp_rdata` = illegal ? 0 : old.
  - `rsp_illegal`.
- FSM states:
  - IDLE: `req_ready` = !flush. Accept → COMMIT.
  - COMMIT (exactly one cycle):
    - Outputs: `csr_explicit_wen` = wpend & !flush; `widx`/`wdata` from the registers; `rsp_valid` = !flush.
    - flush → IDLE, write suppressed, response dropped.
    - Else rsp_ready → IDLE, or → COMMIT if a new request is accepted (bypass build only).
    - Else → HOLD.
  - HOLD:
    - `rsp_valid`=1, `wen`=0; the write has already landed.
    - flush → IDLE, response dropped.
    - rsp_ready → IDLE, or → COMMIT on a same-cycle accept (`req_ready` = rsp_ready & !flush).
- Response registers hold stable while `rsp_valid` & !rsp_ready.
- `flush` has priority over `rsp_ready` and `req_valid` in every state.

## Timing
- While `rst` is high or on its release, all state is cleared and the FSM is in IDLE.
- While `rst` is high, every output is 0, including `req_ready`. After release, `req_ready`=1 in IDLE.
- Latency: accept at cycle N → `wen` and `rsp_valid` at N+1.
- The CSR file writes on the N+1 rising edge, so its rdata reflects the new value from N+2 onward.
- Throughput:
  - With bypass: 1 op/cycle when `rsp_ready` is held high.
  - Without bypass: 1 op per 2 cycles.
- The write occurs even if the response stalls; it is never repeated.

## Configuration
- Macro `LETC_CORE_CSR_AGENT_BYPASS_EN`.
- Defined:
  - COMMIT may accept a new request when rsp_ready & !flush.
  - If the new `req_idx` == registered `widx` and `wpend`, `old` = registered `wdata` instead of `csr_explicit_rdata`.
- Undefined:
  - `req_ready`=0 in COMMIT.
  - No bypass mux; `old` is always taken from the CSR file.

## Test plan
- Reset with `req_valid`=1 → all outputs 0. After release, RW idx 0x340, operand 0x1234, rdata 0xAAAA0000 → next cycle `wen`=1, widx 0x340, wdata 0x1234, `rsp_rdata`=0xAAAA0000.
- CSRRS with src_zero=1, rdata 0x5 → `wcheck`=0, `wen`=0, `rsp_rdata`=0x5. CSRRW with rd_zero=1 → `ren`=0, `rsp_rdata`=0, write still occurs.
- CSRRC operand 0x0F, rdata 0xFF, `csr_explicit_illegal`=1 → `wen`=0, `rsp_illegal`=1, `rsp_rdata`=0. Same access with op=2'b00 and `illegal`=0 → also illegal.
- `flush` in COMMIT → `wen`=0, `rsp_valid`=0, state IDLE. `flush` in HOLD → response dropped, but the write already seen is not undone.
- `rsp_ready`=0 for 3 cycles → `wen` is a single pulse, `rsp_*` stable for 4 cycles, `req_ready`=0 until consumed.
- Bypass build: back-to-back CSRRS on 0x300, operands 0x1 then 0x2, CSR file rdata stale at 0 → second wdata 0x3, second `rsp_rdata` 0x1. Non-bypass build: `req_ready`=0 in COMMIT, second op reads the updated 0x1 from the CSR file.

Source files
------------

// File: rtl/letc_core_csr_agent.sv
`default_nettype none
// ============================================================================
// Module   : letc_core_csr_agent
// Brief    : Zicsr read-modify-write initiator: probes the CSR file, commits the
//            write one cycle later and returns the old value or an illegal flag.
//            Optional build macro LETC_CORE_CSR_AGENT_BYPASS_EN enables
//            back-to-back operation with a write-data bypass.
// Revision : 1.0 - initial release
// ============================================================================
module letc_core_csr_agent (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [11:0] req_idx,
  input  logic [31:0] req_operand,
  input  logic        req_rd_zero,
  input  logic        req_src_zero,
  input  logic        flush,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_illegal,
  output logic        csr_explicit_ren,
  output logic [11:0] csr_explicit_idx,
  input  logic [31:0] csr_explicit_rdata,
  output logic        csr_explicit_wcheck,
  input  logic        csr_explicit_illegal,
  output logic        csr_explicit_wen,
  output logic [11:0] csr_explicit_widx,
  output logic [31:0] csr_explicit_wdata
);

  localparam logic [1:0] C_OP_RSV = 2'b00;
  localparam logic [1:0] C_OP_RW  = 2'b01;
  localparam logic [1:0] C_OP_RS  = 2'b10;
  localparam logic [1:0] C_OP_RC  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COMMIT = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [11:0] r_widx;
  logic [31:0] r_wdata;
  logic        r_wpend;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_illegal;

  logic        w_req_ready;
  logic        w_rsp_valid;
  logic        w_wen;
  logic        w_accept;
  logic        w_is_rw;
  logic        w_ren;
  logic        w_wcheck;
  logic        w_illegal;
  logic [31:0] w_old;
  logic [31:0] w_new;

  // Ready is forced low while reset is asserted so nothing is accepted.
  assign req_ready = w_req_ready & ~rst;
  assign w_accept  = req_valid & req_ready;
  assign w_is_rw   = (req_op == C_OP_RW);
  assign w_ren     = w_accept & ~(w_is_rw & req_rd_zero);
  assign w_wcheck  = w_accept & (w_is_rw | ~req_src_zero);
  assign w_illegal = csr_explicit_illegal | (req_op == C_OP_RSV);

  assign csr_explicit_ren    = w_ren;
  assign csr_explicit_wcheck = w_wcheck;
  assign csr_explicit_idx    = w_accept ? req_idx : 12'h000;

  always_comb begin
    w_old = w_ren ? csr_explicit_rdata : 32'h0;
`ifdef LETC_CORE_CSR_AGENT_BYPASS_EN
    // The CSR file only reflects the committing write from the next cycle on.
    if (w_ren && (r_state == S_COMMIT) && r_wpend && (req_idx == r_widx))
      w_old = r_wdata;
`endif
  end

  always_comb begin
    w_new = req_operand;
    case (req_op)
      C_OP_RW: w_new = req_operand;
      C_OP_RS: w_new = w_old | req_operand;
      C_OP_RC: w_new = w_old & ~req_operand;
      default: w_new = req_operand;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    w_req_ready  = 1'b0;
    w_rsp_valid  = 1'b0;
    w_wen        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req_ready = ~flush;
        if (req_valid && !flush)
          w_next_state = S_COMMIT;
      end
      S_COMMIT: begin
        w_rsp_valid = ~flush;
        w_wen       = r_wpend & ~flush;
`ifdef LETC_CORE_CSR_AGENT_BYPASS_EN
        w_req_ready = rsp_ready & ~flush;
`endif
        if (flush) begin
          w_next_state = S_IDLE;
        end else if (rsp_ready) begin
          w_next_state = S_IDLE;
`ifdef LETC_CORE_CSR_AGENT_BYPASS_EN
          if (req_valid)
            w_next_state = S_COMMIT;
`endif
        end else begin
          w_next_state = S_HOLD;
        end
      end
      S_HOLD: begin
        w_rsp_valid = 1'b1;
        w_req_ready = rsp_ready & ~flush;
        if (flush)
          w_next_state = S_IDLE;
        else if (rsp_ready)
          w_next_state = req_valid ? S_COMMIT : S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next_state;
  end

  // Response and write registers only load on accept, so they hold while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_widx        <= 12'h000;
      r_wdata       <= 32'h0;
      r_wpend       <= 1'b0;
      r_rsp_rdata   <= 32'h0;
      r_rsp_illegal <= 1'b0;
    end else if (w_accept) begin
      r_widx        <= req_idx;
      r_wdata       <= w_new;
      r_wpend       <= w_wcheck & ~w_illegal;
      r_rsp_rdata   <= w_illegal ? 32'h0 : w_old;
      r_rsp_illegal <= w_illegal;
    end
  end

  assign rsp_valid          = w_rsp_valid;
  assign rsp_rdata          = r_rsp_rdata;
  assign rsp_illegal        = r_rsp_illegal;
  assign csr_explicit_wen   = w_wen;
  assign csr_explicit_widx  = r_widx;
  assign csr_explicit_wdata = r_wdata;

endmodule
`default_nettype wire
